// File: rtl/game_score_accum_pkg.sv
// Shared constants, FSM state type and BCD helpers for the game score accumulator.
package score_pkg;

  localparam int unsigned BcdDigitW   = 4;
  localparam int unsigned ScoreDigits = 4;
  localparam int unsigned ConvDigits  = 5;
  localparam int unsigned ScoreW      = ScoreDigits * BcdDigitW;
  localparam int unsigned ConvW       = ConvDigits * BcdDigitW;
  localparam logic [ScoreW-1:0] ScoreSat = 16'h9999;

  typedef enum logic [1:0] {StIdle, StConv, StAdd, StCommit} score_state_e;

  // Double-dabble pre-shift correction: +3 on every digit that is 5 or more.
  function automatic logic [ConvW-1:0] dd_adjust(input logic [ConvW-1:0] bcd);
    logic [ConvW-1:0] res;
    res = bcd;
    for (int unsigned d = 0; d < ConvDigits; d++) begin
      if (bcd[d*BcdDigitW +: BcdDigitW] >= 4'd5) begin
        res[d*BcdDigitW +: BcdDigitW] = bcd[d*BcdDigitW +: BcdDigitW] + 4'd3;
      end
    end
    return res;
  endfunction

  // Returns {carry_out, digit}.
  function automatic logic [BcdDigitW:0] bcd_add_digit(input logic [BcdDigitW-1:0] a,
                                                       input logic [BcdDigitW-1:0] b,
                                                       input logic                 cin);
    logic [BcdDigitW:0] s;
    s = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    if (s > 5'd9) begin
      s = s + 5'd6;
      return {1'b1, s[BcdDigitW-1:0]};
    end
    return {1'b0, s[BcdDigitW-1:0]};
  endfunction

endpackage

// File: rtl/game_score_accum_if.sv
// Request/score bundle between the block controller (master) and the accumulator (slave).
interface game_score_accum_if #(
  parameter int unsigned IN_W = 16
) ();

  logic            clr;
  logic            add_valid;
  logic [IN_W-1:0] add_value;
  logic            add_ready;
  logic [15:0]     game_score;
  logic [15:0]     best_score;
  logic            overflow;
  logic            score_update;

  modport master (
    output clr, add_valid, add_value,
    input  add_ready, game_score, best_score, overflow, score_update
  );

  modport slave (
    input  clr, add_valid, add_value,
    output add_ready, game_score, best_score, overflow, score_update
  );

endinterface

// File: rtl/game_score_accum_bin2bcd_serial.sv
// Serial double-dabble converter: IN_W shift cycles after start_i, done_o marks the last one.
module bin2bcd_serial
  import score_pkg::*;
#(
  parameter int unsigned IN_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [IN_W-1:0]  value_i,
  output logic             done_o,
  output logic [ConvW-1:0] bcd_o
);

  localparam int unsigned CntW = $clog2(IN_W + 1);

  logic [IN_W-1:0]  sr_q;
  logic [ConvW-1:0] bcd_q, bcd_d, bcd_adj;
  logic [CntW-1:0]  cnt_q;
  logic             busy_q;

  always_comb begin
    bcd_adj = dd_adjust(bcd_q);
    bcd_d   = {bcd_adj[ConvW-2:0], sr_q[IN_W-1]};
    done_o  = busy_q && (cnt_q == CntW'(IN_W - 1));
    bcd_o   = bcd_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sr_q   <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (abort_i) begin
      busy_q <= 1'b0;
    end else if (start_i) begin
      sr_q   <= value_i;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      // Result stays in bcd_q after done so the adder and commit can read it.
      sr_q  <= sr_q << 1;
      bcd_q <= bcd_d;
      cnt_q <= cnt_q + 1'b1;
      if (done_o) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/game_score_accum.sv
// Saturating 4-digit BCD score accumulator with valid/ready add requests.
// Optional best-score tracking is built when SCORE_BEST_EN is defined.
module game_score_accum
  import score_pkg::*;
#(
  parameter int unsigned IN_W = 16
) (
  input logic               ClkPort,
  input logic               Reset,
  game_score_accum_if.slave bus
);

  score_state_e state_q, state_d;

  logic              accept, commit, sat;
  logic              conv_done;
  logic [ConvW-1:0]  conv_bcd;
  logic [1:0]        dig_q;
  logic              carry_q;
  logic [ScoreW-1:0] sum_q, new_score;
  logic [ScoreW-1:0] game_score_q, best_q;
  logic              overflow_q, score_update_q;
  logic [BcdDigitW:0] dig_sum;

  assign accept = bus.add_valid && (state_q == StIdle) && !bus.clr;
  assign commit = (state_q == StCommit) && !bus.clr;

  bin2bcd_serial #(
    .IN_W(IN_W)
  ) u_conv (
    .clk_i   (ClkPort),
    .rst_i   (Reset),
    .start_i (accept),
    .abort_i (bus.clr),
    .value_i (bus.add_value),
    .done_o  (conv_done),
    .bcd_o   (conv_bcd)
  );

  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (accept) state_d = StConv;
      StConv:   if (conv_done) state_d = StAdd;
      StAdd:    if (dig_q == 2'd3) state_d = StCommit;
      StCommit: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    if (bus.clr) state_d = StIdle;
  end

  always_comb begin
    bus.add_ready    = (state_q == StIdle);
    bus.game_score   = game_score_q;
    bus.best_score   = best_q;
    bus.overflow     = overflow_q;
    bus.score_update = score_update_q;
  end

  // One score digit per ADD cycle, least significant first.
  always_comb begin
    dig_sum   = bcd_add_digit(conv_bcd[{dig_q, 2'b00} +: BcdDigitW],
                              game_score_q[{dig_q, 2'b00} +: BcdDigitW], carry_q);
    sat       = (conv_bcd[ConvW-1 -: BcdDigitW] != 4'd0) || carry_q;
    new_score = sat ? ScoreSat : sum_q;
  end

  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      dig_q   <= 2'd0;
      carry_q <= 1'b0;
      sum_q   <= '0;
    end else if (state_q == StConv) begin
      dig_q   <= 2'd0;
      carry_q <= 1'b0;
    end else if (state_q == StAdd) begin
      sum_q[{dig_q, 2'b00} +: BcdDigitW] <= dig_sum[BcdDigitW-1:0];
      carry_q <= dig_sum[BcdDigitW];
      dig_q   <= dig_q + 2'd1;
    end
  end

  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      game_score_q   <= '0;
      overflow_q     <= 1'b0;
      score_update_q <= 1'b0;
    end else if (bus.clr) begin
      game_score_q   <= '0;
      overflow_q     <= 1'b0;
      score_update_q <= 1'b0;
    end else begin
      score_update_q <= commit;
      if (commit) begin
        game_score_q <= new_score;
        if (sat) overflow_q <= 1'b1;
      end
    end
  end

`ifdef SCORE_BEST_EN
  // Unsigned compare orders BCD values correctly, digit by digit.
  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      best_q <= '0;
    end else if (commit && (new_score > best_q)) begin
      best_q <= new_score;
    end
  end
`else
  assign best_q = '0;
`endif

endmodule

// File: doc/game_score_accum.md
# game_score_accum

Game-score accumulator for the 2048 VGA design. It sits between the game logic (block controller) and the seven-segment scan logic in the top level. It accepts binary tile-merge values through a valid/ready handshake and converts each value to BCD with a serial double-dabble. It adds the result into a saturating 4-digit BCD score, `game_score[15:0]`, which drives the SSD digits directly, with one hex nibble per decimal digit.

## Interface
- `IN_W`, default 16: width of `add_value`; the conversion takes `IN_W` cycles.
- `ClkPort`, input, 1: system clock, 100 MHz.
- `Reset`, input, 1: reset, asynchronous, active-high. Clock is `ClkPort`.
- `clr`, input, 1: synchronous new-game clear.
- `add_valid`, input, 1: an add request is present.
- `add_value`, input, `IN_W`: unsigned binary amount to add (merged tile value).
- `add_ready`, output, 1: the block can accept a request.
- `game_score`, output, 16: 4-digit BCD score, digit 3 in [15:12].
- `best_score`, output, 16: highest committed `game_score` since `Reset`, in BCD.
- `overflow`, output, 1: sticky flag, set when the score saturates.
- `score_update`, output, 1: one-cycle pulse when `game_score` is committed.

## Operation
- Reset values: `game_score`=0, `best_score`=0, `overflow`=0, `score_update`=0, `add_ready`=1. FSM in IDLE.
- FSM states:
  - IDLE: `add_ready`=1. On `add_valid && add_ready`, capture `add_value`, clear the BCD shift register and go to CONV.
  - CONV: `IN_W` cycles of double-dabble, giving 5 BCD digits (d4..d0). Before each shift, add 3 to every digit that is ≥5. Then go to ADD.
  - ADD: 4 cycles, one digit per cycle, d0 first. Each cycle performs a BCD add of the converted digit, the `game_score` digit and the carry. If the binary sum is >9, add 6 and set carry. Then go to COMMIT.
  - COMMIT: 1 cycle.
    - If d4≠0 or the carry out of digit 3 is 1, `game_score` becomes 16'h9999 and `overflow` is set to 1.
    - Otherwise `game_score` takes the sum.
    - `score_update` pulses and the FSM returns to IDLE.
- Once the score is 9999, every later add keeps 9999. `overflow` stays 1 until `clr` or `Reset`.
- `best_score` updates in COMMIT when the new `game_score` is greater than `best_score`. The compare is a plain 16-bit unsigned compare, which is valid for BCD.
- `clr` has the highest priority, including over an in-flight operation and over a same-cycle `add_valid`.
  - It zeroes `game_score` and `overflow` and returns the FSM to IDLE.
  - The in-flight add is discarded: no commit and no `score_update`.
  - `best_score` is preserved.
  - `add_ready` is 1 in the cycle after `clr`.
- `add_value`=0 is legal. It runs the full sequence, `game_score` is unchanged and `score_update` still pulses.
- A request is not accepted while `add_ready`=0. The producer holds `add_valid` and `add_value` until the handshake completes.

## Timing
- Acceptance happens at edge t, which is the first edge where `add_valid && add_ready`.
- CONV occupies edges t+1 … t+`IN_W`; ADD occupies edges t+`IN_W`+1 … t+`IN_W`+4.
- `game_score` and `score_update` become valid after edge t+`IN_W`+5, which is t+21 for the default.
- `add_ready` drops after edge t and rises after the commit edge. The earliest next acceptance is edge t+`IN_W`+6. Throughput is one add per `IN_W`+6 cycles.
- All outputs are registered. `add_ready` is a decode of the registered state.

## Configuration
- `SCORE_BEST_EN` defined: the `best_score` register and compare are present as described.
- `SCORE_BEST_EN` not defined: `best_score` is tied to 16'h0000 and no compare logic is built. All other behaviour is identical.

## Structure
- Package `score_pkg`:
  - constants: BCD digit width (4), score digit count (4), conversion digit count (5), saturation value 16'h9999
  - FSM state typedef: IDLE, CONV, ADD, COMMIT
- Sub-module `bin2bcd_serial`: the double-dabble engine.
  - Interface: `start`, a `done` pulse, `IN_W` binary input, 20-bit BCD output.
  - Instantiated once and started from IDLE on acceptance.
  - Aborted by `clr` or `Reset`.
- The top level owns the handshake, the digit-serial BCD adder, saturation, `overflow`, `best_score` and the `score_update` pulse.

## Test plan
- Reset check: assert `Reset` mid-CONV, then release. Expect `game_score`=0000, `best_score`=0000, `overflow`=0, `add_ready`=1, and no `score_update`.
- Add sequence and latency: add 4, then 8, then 2048. Expect `game_score` 0004 → 0012 → 2060. Each `score_update` occurs exactly 21 edges after acceptance, and `add_ready`=0 throughout.
- Saturation from carry: with score 9990, add 16. Expect `game_score`=9999 and `overflow`=1. A following add of 2 keeps 9999 and `overflow`=1.
- Saturation from a large value: from 0000, add 12345 (d4=1). Expect 9999 and `overflow`=1.
- Clear mid-operation: assert `clr` 5 cycles after accepting 64 with score 0100. Expect `game_score`=0000, no `score_update`, and `best_score`=0100. The next add of 2 gives 0002.
- Best score: reach 0100, `clr`, then reach 0050. Expect `best_score`=0100; reaching 0200 then updates it to 0200. Without `SCORE_BEST_EN`, `best_score`=0000 throughout.
